// File: rtl/axi_ch_pkg.sv
// Shared encodings and LFSR helper for the axi_ch_sink slave model.
package axi_ch_pkg;

  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'd0,
    MODE_DELAY  = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RDY  = 2'd2
  } dly_state_e;

  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
  localparam logic [15:0] LFSR_TAPS      = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/axi_ch_sink_if.sv
// Channel (valid/ready/data) plus show-ahead pop side of the sink.
interface axi_ch_sink_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              cs;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output valid, data, out_ready,
    input  ready, cs, out_valid, out_data
  );

  modport slave (
    input  valid, data, out_ready,
    output ready, cs, out_valid, out_data
  );
endinterface

// File: rtl/axi_ch_fifo.sv
// Circular-buffer FIFO with show-ahead head; push visible one cycle later.
// Pop on empty and push on full are ignored; level_nxt feeds the ready register.
module axi_ch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   anreset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign not_empty = (level != '0);
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (level != FULL_LVL);
  assign head      = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) level_nxt = level + (PTR_W+1)'(1);
    else if (!do_push && do_pop) level_nxt = level - (PTR_W+1)'(1);
  end

  // Storage is not reset; pointers and level alone define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/axi_ch_sink.sv
// Valid/ready channel sink: registered ready under ALWAYS/DELAY/RANDOM policy,
// capture into FIFO (head valid 1 cycle after cs), transfer counter.
module axi_ch_sink
  import axi_ch_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DFLT
) (
  input  logic                   clk,
  input  logic                   anreset,
  input  logic [1:0]             mode,
  input  logic [3:0]             delay,
  axi_ch_sink_if.slave           ch,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       xfer_count,
  input  logic                   clr_count
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  dly_state_e        state;
  dly_state_e        state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [1:0]        mode_q;
  logic              mode_q_vld;
  logic              mode_chg;
  logic              rdy_q;
  logic              policy_ok;
  logic              pop;
  logic              fifo_ne;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head;

  assign ch.ready     = rdy_q;
  assign ch.cs        = ch.valid & rdy_q;
  assign ch.out_valid = fifo_ne;
  assign ch.out_data  = head;
  assign pop          = ch.out_ready & fifo_ne;
  assign lfsr_nxt     = lfsr_step(lfsr);
  // mode_q_vld keeps the first cycle after reset from looking like a mode change
  assign mode_chg     = mode_q_vld & (mode != mode_q);

  axi_ch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .anreset   (anreset),
    .push      (ch.cs),
    .push_data (ch.data),
    .pop       (pop),
    .head      (head),
    .not_empty (fifo_ne),
    .level     (level),
    .level_nxt (level_nxt)
  );

  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lfsr       <= LFSR_SEED;
      mode_q     <= MODE_ALWAYS;
      mode_q_vld <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lfsr       <= lfsr_nxt;
      mode_q     <= mode;
      mode_q_vld <= 1'b1;
      rdy_q      <= policy_ok & (level_nxt != FULL_LVL);
    end
  end

  // Policy is judged on the next state so ready lands exactly delay+1 cycles after valid.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    policy_ok = 1'b1;
    if (mode_chg || (mode != MODE_DELAY)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ch.valid) begin
            if (delay == 4'd0) begin
              state_nxt = ST_RDY;
            end else begin
              cnt_nxt   = delay - 4'd1;
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!ch.valid)          state_nxt = ST_IDLE;
          else if (cnt == 4'd0)   state_nxt = ST_RDY;
          else                    cnt_nxt   = cnt - 4'd1;
        end
        ST_RDY: begin
          if (ch.cs || !ch.valid) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    case (mode)
      MODE_DELAY:  policy_ok = (state_nxt == ST_RDY);
      MODE_RANDOM: policy_ok = lfsr_nxt[0];
      default:     policy_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset)       xfer_count <= '0;
    else if (clr_count) xfer_count <= CNT_W'(ch.cs);
    else                xfer_count <= xfer_count + CNT_W'(ch.cs);
  end

endmodule

// File: tb/tb_axi_ch_sink.sv
// Directed bench for axi_ch_sink with a queue/counter reference model checked every cycle.
module tb_axi_ch_sink;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        anreset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  delay = 4'd0;
  logic [2:0]  level;
  logic [15:0] xfer_count;
  logic        clr_count = 1'b0;

  int total = 0;
  int bad = 0;

  axi_ch_sink_if #(.DATA_W(32)) ch ();

  axi_ch_sink #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .anreset    (anreset),
    .mode       (mode),
    .delay      (delay),
    .ch         (ch),
    .level      (level),
    .xfer_count (xfer_count),
    .clr_count  (clr_count)
  );

  always #5 clk = ~clk;

  // Reference model: word queue, counter, LFSR, and a count of consecutive
  // valid-high cycles in DELAY mode since the last restart point.
  logic [31:0] m_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_cnt = 16'd0;
  bit          m_ready = 1'b0;
  int          m_seen = 0;
  logic [1:0]  m_pmode = 2'd0;
  bit          m_pmode_vld = 1'b0;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always @(posedge clk or negedge anreset) begin
    bit cs_m;
    bit pop_m;
    bit chg;
    bit pol;
    if (!anreset) begin
      m_q.delete();
      m_lfsr      = 16'hACE1;
      m_cnt       = 16'd0;
      m_ready     = 1'b0;
      m_seen      = 0;
      m_pmode_vld = 1'b0;
    end else begin
      cs_m  = ch.valid && m_ready;
      pop_m = (m_q.size() > 0) && ch.out_ready;
      if (pop_m) void'(m_q.pop_front());
      if (cs_m) m_q.push_back(ch.data);
      m_cnt = clr_count ? 16'(cs_m) : m_cnt + 16'(cs_m);
      chg = m_pmode_vld && (mode != m_pmode);
      m_pmode = mode;
      m_pmode_vld = 1'b1;
      m_lfsr = lfsr_adv(m_lfsr);
      if (mode != 2'd1 || chg || !ch.valid || cs_m) m_seen = 0;
      else if (m_seen < 100) m_seen++;
      case (mode)
        2'd1:    pol = (m_seen >= int'(delay) + 1);
        2'd2:    pol = m_lfsr[0];
        default: pol = 1'b1;
      endcase
      m_ready = pol && (m_q.size() != DEPTH);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready", 32'(ch.ready), 32'(m_ready));
    chk("cs", 32'(ch.cs), 32'(ch.valid & m_ready));
    chk("out_valid", 32'(ch.out_valid), 32'(m_q.size() > 0));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    if (m_q.size() > 0) chk("out_data", ch.out_data, m_q[0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends n words, each held until accepted; checks cycles from valid to ready.
  task automatic send_words(input int n, input int exp_lat, input logic [31:0] base);
    int sent = 0;
    int lat = 0;
    int budget = 0;
    ch.valid = 1'b1;
    ch.data  = base;
    while (sent < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (ch.cs) begin
        chk("valid_to_ready", 32'(lat), 32'(exp_lat));
        sent++;
        lat = 0;
      end else begin
        lat++;
      end
      tick();
      ch.data  = base + 32'(sent);
      ch.valid = (sent < n);
    end
    ch.valid = 1'b0;
    chk("words_sent", 32'(sent), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int ncs;
    int k;
    int nrdy;
    int idx;
    logic [15:0] c0;
    logic [4:0] rv;
    logic [31:0] got[$];

    ch.valid = 1'b1;
    ch.data = 32'h11;
    ch.out_ready = 1'b0;

    // 1: reset with valid held, then ALWAYS capture
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", 32'(ch.ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    tick();
    anreset = 1'b1;
    tick();
    @(negedge clk);
    chk("ready_after_release", 32'(ch.ready), 32'd1);
    tick();
    ch.data = 32'h22;
    @(negedge clk);
    chk("head_after_first_cs", ch.out_data, 32'h11);
    tick();
    ch.data = 32'h33;
    tick();
    ch.valid = 1'b0;
    tick();
    chk("three_captured", 32'(level), 32'd3);
    chk("three_counted", 32'(xfer_count), 32'd3);
    ch.out_ready = 1'b1;
    repeat (5) tick();

    // 2: DELAY policy
    mode = 2'd1;
    delay = 4'd0;
    repeat (3) tick();
    c0 = xfer_count;
    send_words(4, 1, 32'h40);
    chk("delay0_count", 32'(xfer_count - c0), 32'd4);
    delay = 4'd3;
    repeat (2) tick();
    c0 = xfer_count;
    send_words(3, 4, 32'h50);
    chk("delay3_count", 32'(xfer_count - c0), 32'd3);
    repeat (3) tick();

    // 3: fill to full, then free one slot
    mode = 2'd0;
    repeat (3) tick();
    ch.out_ready = 1'b0;
    ch.valid = 1'b1;
    ch.data = 32'hA0;
    ncs = 0;
    repeat (8) begin
      @(negedge clk);
      if (ch.cs) ncs++;
      tick();
      ch.data = 32'hA0 + 32'(ncs);
    end
    chk("fill_xfers", 32'(ncs), 32'd4);
    @(negedge clk);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(ch.ready), 32'd0);
    tick();
    ch.out_ready = 1'b1;
    tick();
    ch.out_ready = 1'b0;
    @(negedge clk);
    chk("refill_ready", 32'(ch.ready), 32'd1);
    chk("fifth_xfer", 32'(ch.cs), 32'd1);
    chk("refill_level", 32'(level), 32'd3);
    tick();
    @(negedge clk);
    chk("refull_level", 32'(level), 32'd4);
    chk("refull_ready", 32'(ch.ready), 32'd0);
    tick();
    ch.valid = 1'b0;
    ch.out_ready = 1'b1;
    repeat (6) tick();

    // 4: RANDOM from the default seed
    anreset = 1'b0;
    mode = 2'd2;
    ch.valid = 1'b1;
    ch.data = 32'h77;
    tick();
    anreset = 1'b1;
    nrdy = 0;
    rv = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 3) chk("model_lfsr_3", 32'(m_lfsr), 32'h559C);
      if (i >= 1 && i <= 5) rv[i-1] = ch.ready;
      if (m_ready) nrdy++;
    end
    chk("rand_ready_first5", 32'(rv), 32'h10);
    tick();
    chk("rand_xfers", 32'(xfer_count), 32'(nrdy));
    ch.valid = 1'b0;

    // 5: ordering through wrap-around with random pop
    mode = 2'd0;
    repeat (6) tick();
    idx = 0;
    ch.valid = 1'b1;
    ch.data = 32'd0;
    for (int cyc = 0; cyc < 300 && got.size() < 10; cyc++) begin
      @(negedge clk);
      if (ch.cs) idx++;
      if (ch.out_valid && ch.out_ready) got.push_back(ch.out_data);
      tick();
      ch.valid = (idx < 10);
      ch.data = 32'(idx);
      ch.out_ready = 1'($urandom_range(0, 1));
    end
    chk("wrap_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) chk("wrap_order", got[i], 32'(i));
    ch.valid = 1'b0;
    ch.out_ready = 1'b1;
    repeat (6) tick();

    // 6: clear coincident with a transfer, then reset mid-stream in DELAY
    ch.valid = 1'b1;
    ch.data = 32'hB0;
    repeat (2) tick();
    clr_count = 1'b1;
    @(negedge clk);
    chk("clr_cycle_cs", 32'(ch.cs), 32'd1);
    tick();
    clr_count = 1'b0;
    ch.valid = 1'b0;
    chk("clr_with_cs", 32'(xfer_count), 32'd1);
    mode = 2'd1;
    delay = 4'd2;
    ch.out_ready = 1'b0;
    repeat (3) tick();
    send_words(2, 3, 32'hC0);
    ch.valid = 1'b1;
    repeat (3) tick();
    chk("ready_before_reset", 32'(ch.ready), 32'd1);
    anreset = 1'b0;
    #1;
    chk("midrst_ready", 32'(ch.ready), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_valid", 32'(ch.out_valid), 32'd0);
    tick();
    anreset = 1'b1;
    k = 0;
    @(negedge clk);
    while (!ch.ready && k < 10) begin
      k++;
      @(negedge clk);
    end
    chk("ready_lat_after_reset", 32'(k), 32'd3);
    tick();
    ch.valid = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ch_sink.md
Name: axi_ch_sink

Overview:
- Parametrised receiving end of one AXI-style valid/ready channel.
- Generates `ready` under a selectable backpressure policy: always-ready, delayed-ready, or pseudo-random.
- Captures each transferred data word into an internal FIFO and presents it on a show-ahead pop interface.
- Counts completed transfers; used as a configurable slave model and front-end in the axirandom test environment.

Parameters:
- DATA_W, 32, channel data width in bits (>=1).
- DEPTH, 4, FIFO depth in words; power of two, >=2.
- CNT_W, 16, width of the transfer counter.
- LFSR_SEED, 16'hACE1, reset value of the random-mode LFSR; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- anreset  in  1  asynchronous reset, active low.
- mode  in  2  ready policy: 0 ALWAYS, 1 DELAY, 2 RANDOM, 3 reserved (behaves as ALWAYS).
- delay  in  4  DELAY-mode wait in cycles.
- valid  in  1  channel valid from master.
- data  in  DATA_W  channel data.
- ready  out  1  channel ready; registered.
- cs  out  1  transfer strobe = valid & ready; combinational.
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_W  FIFO head word.
- out_ready  in  1  pop request; pop = out_valid & out_ready.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- xfer_count  out  CNT_W  completed transfers.
- clr_count  in  1  synchronous clear of xfer_count.

Behaviour:
Reset (anreset low, asynchronous):
- ready=0, out_valid=0, level=0, xfer_count=0.
- FSM=IDLE, LFSR=LFSR_SEED.
- Asserting reset mid-operation discards FIFO contents.

Transfer:
- A transfer occurs on a rising edge with cs=1; data is written into the FIFO on the same edge.

Ready register:
- ready_next = policy_ok & (level_next != DEPTH).
- level_next = level + cs - pop.
- ready is never 1 while the FIFO is full, so overflow is impossible.

ALWAYS policy:
- policy_ok = 1.

DELAY policy (FSM IDLE/WAIT/RDY, down-counter cnt):
- IDLE: valid=1 and delay=0 -> RDY. valid=1 and delay>0 -> load cnt=delay-1, go to WAIT.
- WAIT: valid=0 -> IDLE. cnt=0 -> RDY. Otherwise cnt decrements.
- RDY: policy_ok=1. On cs -> IDLE. On valid=0 -> IDLE.
- ready rises delay+1 cycles after the first cycle valid is seen high. delay=0 gives the one-cycle edge-ready legacy behaviour.
- Back-to-back valid after cs restarts the delay from IDLE.
- FIFO full in RDY: FSM holds RDY with ready=0 until space frees.

RANDOM policy:
- 16-bit Fibonacci LFSR, taps 16,14,13,11; shifts every cycle in every mode.
- policy_ok = lfsr[0].

Mode changes:
- Any change of mode forces the FSM to IDLE on the next edge.
- ready re-evaluates under the new policy from that edge.

FIFO:
- Circular buffer with wrap-around pointers.
- out_data is the head word, valid whenever out_valid=1.
- No bypass: push into an empty FIFO gives out_valid=1 on the next cycle (1-cycle latency).
- Simultaneous push and pop: level unchanged.
- Pop when empty: ignored.

Counter:
- xfer_count += cs, wrapping modulo 2^CNT_W.
- clr_count=1: xfer_count <= cs, so a clear coincident with a transfer yields 1.

Valid dropping without a transfer:
- Tolerated (test environment). No capture occurs.

Decomposition:
- Package axi_ch_pkg holds:
  - mode encodings MODE_ALWAYS=0, MODE_DELAY=1, MODE_RANDOM=2;
  - FSM state encodings;
  - LFSR tap mask;
  - default seed.
- One sub-module, axi_ch_fifo (DATA_W, DEPTH): push/pop/level/head.
- Policy logic, FSM, LFSR and counter stay in the top module.

Test Plan:
1. Reset with valid=1 held -> ready=0, level=0, xfer_count=0 during reset. After release in mode 0: ready=1 on the second edge; data 0x11,0x22,0x33 captured; out_data=0x11 one cycle after first cs.
2. Mode 1, delay=0, single valid pulse train -> ready rises 1 cycle after valid, one cs per word. delay=3 -> ready rises exactly 4 cycles after valid, cs count matches words sent.
3. Mode 0, DEPTH=4, out_ready=0, valid held -> exactly 4 transfers, then ready=0, level=4. One pop -> ready=1 next cycle, fifth transfer, level back to 4.
4. Mode 2, default seed, 64 cycles, valid=1, out_ready=1 -> ready sequence equals lfsr[0] model; xfer_count equals number of ready-high cycles.
5. Data ordering across wrap-around -> 10 words 0x0..0x9 through DEPTH=4 with random out_ready produce out_data in order 0x0..0x9, no loss or duplication.
6. clr_count asserted on a cs cycle -> xfer_count=1. anreset pulsed mid-stream in mode 1 -> FSM IDLE, FIFO empty, ready=0 immediately.
